tape_controller: RTL

//  Parametrised Turing-machine tape: a DEPTH x SYM_W symbol store plus a head pointer.

---
 rtl/tape_pkg.sv | 29 ++
 rtl/tape_mem.sv | 34 +++
 rtl/tape_controller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/tape_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tape_pkg
// Description : Shared types for the Turing-machine tape controller: head
//               move encoding, controller states and the step counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package tape_pkg;

  // Head movement requested by a command; RSVD behaves like STAY
  typedef enum logic [1:0] {
    STAY  = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10,
    RSVD  = 2'b11
  } move_t;

  // Controller states
  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    IDLE  = 2'b01,
    EXEC  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam int STEP_W = 16;

endpackage
`default_nettype wire

// File: rtl/tape_mem.sv
`default_nettype none
// ============================================================================
// Module      : tape_mem
// Description : DEPTH x SYM_W tape storage with one synchronous write port and
//               one combinational read port. Contents are not reset; the
//               controller blanks them with its clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tape_mem #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [SYM_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [SYM_W-1:0] rdata
);

  logic [SYM_W-1:0] mem [DEPTH];

  // Synchronous write; addresses are always kept below DEPTH by the controller
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/tape_controller.sv
`default_nettype none
// ============================================================================
// Module      : tape_controller
// Description : Turing-machine tape: symbol store plus head pointer. Accepts
//               write/move commands on a valid/ready handshake and answers
//               with the symbol under the new head position.
//               Optional feature macro: TAPE_STEP_COUNT_EN (saturating count
//               of accepted commands on step_count; tied to 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module tape_controller
  import tape_pkg::*;
#(
  parameter int               SYM_W = 2,
  parameter int               DEPTH = 16,
  parameter logic [SYM_W-1:0] BLANK = '0,
  parameter bit               WRAP  = 1'b0,
  localparam int              AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_L,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [SYM_W-1:0]  cmd_sym,
  input  logic [1:0]        cmd_move,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [SYM_W-1:0]  rsp_sym,
  output logic              rsp_edge,
  output logic [AW-1:0]     head_pos,
  output logic [STEP_W-1:0] step_count
);

  // Last legal cell index, held one bit wider so head arithmetic cannot alias
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  state_t           state, state_nx;
  logic [AW-1:0]    clr_idx;
  logic [AW-1:0]    head;
  logic             lat_write;
  logic [SYM_W-1:0] lat_sym;
  move_t            lat_move;
  logic             edge_q;

  logic             accept;
  logic [AW:0]      head_ext;
  logic [AW-1:0]    head_nx;
  logic             edge_nx;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [SYM_W-1:0] mem_wdata;
  logic [SYM_W-1:0] mem_rdata;

  assign accept = cmd_valid & cmd_ready;

  // Next head position for the latched move; blocked moves set the edge flag
  always_comb begin
    head_ext = {1'b0, head};
    head_nx  = head;
    edge_nx  = 1'b0;
    case (lat_move)
      LEFT: begin
        if (head_ext == '0) begin
          if (WRAP) head_nx = LAST[AW-1:0];
          else      edge_nx = 1'b1;
        end else begin
          head_nx = AW'(head_ext - 1'b1);
        end
      end
      RIGHT: begin
        if (head_ext == LAST) begin
          if (WRAP) head_nx = '0;
          else      edge_nx = 1'b1;
        end else begin
          head_nx = AW'(head_ext + 1'b1);
        end
      end
      default: begin
        head_nx = head;
      end
    endcase
  end

  // Controller state register
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= CLEAR;
    else          state <= state_nx;
  end

  // Next state, handshake and memory write-port mux (clear sweep vs EXEC)
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = clr_idx;
    mem_wdata = BLANK;
    case (state)
      CLEAR: begin
        mem_we = 1'b1;
        if ({1'b0, clr_idx} == LAST) state_nx = IDLE;
      end
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = EXEC;
      end
      EXEC: begin
        mem_we    = lat_write;
        mem_waddr = head;
        mem_wdata = lat_sym;
        state_nx  = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: begin
        state_nx = CLEAR;
      end
    endcase
  end

  // Clear index, command latch, head pointer and edge flag
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      clr_idx   <= '0;
      head      <= '0;
      lat_write <= 1'b0;
      lat_sym   <= '0;
      lat_move  <= STAY;
      edge_q    <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        clr_idx <= ({1'b0, clr_idx} == LAST) ? '0 : clr_idx + 1'b1;
      end
      if (accept) begin
        lat_write <= cmd_write;
        lat_sym   <= cmd_sym;
        lat_move  <= move_t'(cmd_move);
      end
      if (state == EXEC) begin
        head   <= head_nx;
        edge_q <= edge_nx;
      end
    end
  end

  tape_mem #(
    .SYM_W (SYM_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (head),
    .rdata (mem_rdata)
  );

  // Response is only driven in RESP, so reset forces it to zero immediately
  assign rsp_valid = (state == RESP);
  assign rsp_sym   = rsp_valid ? mem_rdata : '0;
  assign rsp_edge  = rsp_valid & edge_q;
  assign head_pos  = head;

`ifdef TAPE_STEP_COUNT_EN
  logic [STEP_W-1:0] step_q;

  // Saturating count of accepted commands, cleared only by reset
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      step_q <= '0;
    end else if (accept && (step_q != {STEP_W{1'b1}})) begin
      step_q <= step_q + 1'b1;
    end
  end

  assign step_count = step_q;
`else
  assign step_count = '0;
`endif

endmodule
`default_nettype wire
